// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, addresses the combinational instruction ROM
// and registers the fetched word for decode, handling stall, redirect and halt.
module fetch_stage #(
   parameter int                 ADDR_W    = 10,
   parameter int                 INSTR_W   = 10,
   parameter logic [ADDR_W-1:0]  RESET_PC  = 10'd1,
   parameter logic [INSTR_W-1:0] HALT_WORD = 10'b0010000010
) (
   input  logic               clk,
   input  logic               reset,
   output logic [ADDR_W-1:0]  rom_addr,
   input  logic [INSTR_W-1:0] rom_data,
   input  logic               stall,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_target,
   output logic [INSTR_W-1:0] instr_out,
   output logic [ADDR_W-1:0]  instr_pc,
   output logic               instr_valid,
   output logic               halted
);

   typedef enum logic {RUN, HALT} state_t;

   state_t             state, state_next;
   logic [ADDR_W-1:0]  pc, pc_next;
   logic [INSTR_W-1:0] out_next;
   logic [ADDR_W-1:0]  out_pc_next;
   logic               valid_next;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= RUN;
         pc          <= RESET_PC;
         instr_out   <= '0;
         instr_pc    <= '0;
         instr_valid <= 1'b0;
      end else begin
         state       <= state_next;
         pc          <= pc_next;
         instr_out   <= out_next;
         instr_pc    <= out_pc_next;
         instr_valid <= valid_next;
      end
   end

   // Redirect beats stall beats halt; a fetched halt word freezes the PC on itself.
   always_comb begin
      state_next  = state;
      pc_next     = pc;
      out_next    = instr_out;
      out_pc_next = instr_pc;
      valid_next  = instr_valid;
      if (redirect_valid) begin
         pc_next    = redirect_target;
         valid_next = 1'b0;
         state_next = RUN;
      end else if (stall) begin
         state_next = state;
      end else if (state == HALT) begin
         valid_next = 1'b0;
      end else begin
         out_next    = rom_data;
         out_pc_next = pc;
         valid_next  = 1'b1;
         if (rom_data == HALT_WORD) begin
            state_next = HALT;
         end else begin
            pc_next = pc + ADDR_W'(1);
         end
      end
   end

   assign rom_addr = pc;
   assign halted   = (state == HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized traffic,
// all compared against a behavioural model of the fetch rules.
module tb_fetch_stage;

   localparam logic [9:0] HALT = 10'b0010000010;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [9:0] rom_addr;
   logic [9:0] rom_data;
   logic       stall = 1'b0;
   logic       redirect_valid = 1'b0;
   logic [9:0] redirect_target = '0;
   logic [9:0] instr_out;
   logic [9:0] instr_pc;
   logic       instr_valid;
   logic       halted;

   logic [9:0] rom [0:1023];

   int checks = 0;
   int passed = 0;

   // Behavioural model of the stage.
   int         m_pc;
   logic [9:0] m_out;
   int         m_ipc;
   logic       m_valid;
   logic       m_halted;

   fetch_stage dut (
      .clk(clk),
      .reset(reset),
      .rom_addr(rom_addr),
      .rom_data(rom_data),
      .stall(stall),
      .redirect_valid(redirect_valid),
      .redirect_target(redirect_target),
      .instr_out(instr_out),
      .instr_pc(instr_pc),
      .instr_valid(instr_valid),
      .halted(halted)
   );

   assign rom_data = rom[rom_addr];

   always #5 clk = ~clk;

   // One clock with the given inputs; model advances on the same edge, outputs sampled 1ns later.
   task automatic step(input logic r, input logic s, input logic rv, input int t);
      @(negedge clk);
      reset = r;
      stall = s;
      redirect_valid = rv;
      redirect_target = 10'(t);
      @(posedge clk);
      if (r) begin
         m_pc = 1; m_out = '0; m_ipc = 0; m_valid = 1'b0; m_halted = 1'b0;
      end else if (rv) begin
         m_pc = t; m_valid = 1'b0; m_halted = 1'b0;
      end else if (s) begin
         m_pc = m_pc;
      end else if (m_halted) begin
         m_valid = 1'b0;
      end else begin
         m_out = rom[m_pc];
         m_ipc = m_pc;
         m_valid = 1'b1;
         if (rom[m_pc] == HALT) m_halted = 1'b1;
         else m_pc = (m_pc + 1) % 1024;
      end
      #1;
   endtask

   task automatic test_reset;
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      checks++;
      if ({rom_addr, instr_valid, halted, instr_pc, instr_out} !== {10'd1, 1'b0, 1'b0, 10'd0, 10'd0})
         $display("[TB] FAIL reset_state: got addr=%0d valid=%b halted=%b pc=%0d out=%0d want 1/0/0/0/0",
                  rom_addr, instr_valid, halted, instr_pc, instr_out);
      else passed++;
      step(0, 0, 0, 0);
      checks++;
      if ({instr_pc, instr_out, instr_valid, rom_addr} !== {10'd1, rom[1], 1'b1, 10'd2})
         $display("[TB] FAIL first_fetch: got pc=%0d out=%0d valid=%b addr=%0d want 1/%0d/1/2",
                  instr_pc, instr_out, instr_valid, rom_addr, rom[1]);
      else passed++;
   endtask

   task automatic test_stall;
      logic [9:0] hold_out, hold_pc;
      logic       hold_valid;
      repeat (3) step(0, 0, 0, 0);
      hold_out = instr_out; hold_pc = instr_pc; hold_valid = instr_valid;
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 0, 0);
         checks++;
         if ({rom_addr, instr_out, instr_pc, instr_valid} !== {10'd5, hold_out, hold_pc, hold_valid})
            $display("[TB] FAIL stall_hold: got addr=%0d out=%0d pc=%0d valid=%b want 5/%0d/%0d/%b",
                     rom_addr, instr_out, instr_pc, instr_valid, hold_out, hold_pc, hold_valid);
         else passed++;
      end
      step(0, 0, 0, 0);
      checks++;
      if ({instr_pc, rom_addr} !== {10'd5, 10'd6})
         $display("[TB] FAIL stall_release: got pc=%0d addr=%0d want 5/6", instr_pc, rom_addr);
      else passed++;
   endtask

   task automatic test_redirect;
      int tgt;
      repeat (10) step(0, 0, 0, 0);
      checks++;
      if (rom_addr !== 10'd16)
         $display("[TB] FAIL redirect_setup: got addr=%0d want 16", rom_addr);
      else passed++;
      step(0, 0, 1, 4);
      checks++;
      if ({rom_addr, instr_valid} !== {10'd4, 1'b0})
         $display("[TB] FAIL redirect_taken: got addr=%0d valid=%b want 4/0", rom_addr, instr_valid);
      else passed++;
      step(0, 0, 0, 0);
      checks++;
      if ({instr_pc, instr_valid} !== {10'd4, 1'b1})
         $display("[TB] FAIL redirect_fetch: got pc=%0d valid=%b want 4/1", instr_pc, instr_valid);
      else passed++;
      tgt = $urandom_range(20, 90);
      step(0, 1, 1, tgt);
      checks++;
      if ({rom_addr, instr_valid} !== {10'(tgt), 1'b0})
         $display("[TB] FAIL redirect_stall: got addr=%0d valid=%b want %0d/0", rom_addr, instr_valid, tgt);
      else passed++;
   endtask

   task automatic test_halt;
      step(0, 0, 1, 15);
      repeat (3) step(0, 0, 0, 0);
      checks++;
      if ({instr_pc, instr_valid, halted, rom_addr, instr_out} !== {10'd17, 1'b1, 1'b1, 10'd17, HALT})
         $display("[TB] FAIL halt_issue: got pc=%0d valid=%b halted=%b addr=%0d out=%0d want 17/1/1/17/%0d",
                  instr_pc, instr_valid, halted, rom_addr, instr_out, HALT);
      else passed++;
      for (int i = 0; i < 6; i++) begin
         step(0, 0, 0, 0);
         checks++;
         if ({instr_valid, halted, rom_addr, instr_pc} !== {1'b0, 1'b1, 10'd17, 10'd17})
            $display("[TB] FAIL halt_frozen: got valid=%b halted=%b addr=%0d pc=%0d want 0/1/17/17",
                     instr_valid, halted, rom_addr, instr_pc);
         else passed++;
      end
      step(0, 0, 1, 4);
      checks++;
      if ({halted, rom_addr, instr_valid} !== {1'b0, 10'd4, 1'b0})
         $display("[TB] FAIL halt_redirect: got halted=%b addr=%0d valid=%b want 0/4/0",
                  halted, rom_addr, instr_valid);
      else passed++;
      step(0, 0, 0, 0);
      checks++;
      if ({instr_pc, instr_valid, rom_addr} !== {10'd4, 1'b1, 10'd5})
         $display("[TB] FAIL halt_resume: got pc=%0d valid=%b addr=%0d want 4/1/5", instr_pc, instr_valid, rom_addr);
      else passed++;
   endtask

   task automatic test_wrap;
      step(0, 0, 1, 1023);
      step(0, 0, 0, 0);
      checks++;
      if ({instr_pc, instr_valid, rom_addr, halted} !== {10'd1023, 1'b1, 10'd0, 1'b0})
         $display("[TB] FAIL pc_wrap: got pc=%0d valid=%b addr=%0d halted=%b want 1023/1/0/0",
                  instr_pc, instr_valid, rom_addr, halted);
      else passed++;
   endtask

   task automatic test_reset_override;
      step(0, 0, 1, 17);
      step(0, 0, 0, 0);
      checks++;
      if (halted !== 1'b1)
         $display("[TB] FAIL reset_setup: got halted=%b want 1", halted);
      else passed++;
      step(1, 1, 1, 300);
      checks++;
      if ({rom_addr, halted, instr_valid} !== {10'd1, 1'b0, 1'b0})
         $display("[TB] FAIL reset_halted: got addr=%0d halted=%b valid=%b want 1/0/0", rom_addr, halted, instr_valid);
      else passed++;
      repeat (4) step(0, 0, 0, 0);
      step(1, 1, 0, 0);
      checks++;
      if ({rom_addr, halted, instr_valid} !== {10'd1, 1'b0, 1'b0})
         $display("[TB] FAIL reset_stalled: got addr=%0d halted=%b valid=%b want 1/0/0", rom_addr, halted, instr_valid);
      else passed++;
   endtask

   task automatic test_random;
      logic r, s, rv;
      int   t;
      for (int i = 0; i < 400; i++) begin
         r  = ($urandom_range(0, 99) < 2);
         s  = ($urandom_range(0, 99) < 25);
         rv = ($urandom_range(0, 99) < 8);
         t  = ($urandom_range(0, 3) == 0) ? $urandom_range(195, 205) : $urandom_range(0, 1023);
         step(r, s, rv, t);
         checks++;
         if ({rom_addr, instr_out, instr_pc, instr_valid, halted} !==
             {10'(m_pc), m_out, 10'(m_ipc), m_valid, m_halted})
            $display("[TB] FAIL random_%0d: got addr=%0d out=%0d pc=%0d valid=%b halted=%b want %0d/%0d/%0d/%b/%b",
                     i, rom_addr, instr_out, instr_pc, instr_valid, halted, m_pc, m_out, m_ipc, m_valid, m_halted);
         else passed++;
      end
   endtask

   initial begin
      for (int a = 0; a < 1024; a++) begin
         logic [9:0] w;
         w = 10'($urandom_range(0, 1023));
         if (w == HALT) w = ~w;
         rom[a] = w;
      end
      rom[17]  = HALT;
      rom[200] = HALT;
      rom[600] = HALT;
      m_pc = 1; m_out = '0; m_ipc = 0; m_valid = 1'b0; m_halted = 1'b0;
      test_reset;
      test_stall;
      test_redirect;
      test_halt;
      test_wrap;
      test_reset_override;
      test_random;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
